// File: rtl/control_pkg.sv
// Shared encodings for the multicycle main control unit: state enum, opcodes,
// ALUOp codes and ALU operand select codes.
// Pure constants and types; no timing or flow control of its own.
package control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_REG    = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: Moore outputs from the state register; lw 5, sw 4, R 4, beq 3, illegal 2 cycles.
// Backpressure: stalls in FETCH, MEM_READ and MEM_WRITE until mem_ready, outputs held.
//
// Ports:
//   clk, rst_n              clock, async active-low reset (forces FETCH)
//   opcode/funct3/funct7_5  instruction register fields
//   mem_ready               memory finishes the current access this cycle
//   pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
//   reg_write, mem_to_reg, alu_src_a, alu_src_b   datapath controls
//   alu_control_input       {ALUOp, funct7_5, funct3} for the ALU control decoder
//   illegal_instr           one-cycle pulse in DECODE on an unsupported opcode
//   state_o                 current state, debug only
module main_control_fsm
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [5:0] alu_control_input,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  state_t     state, state_nxt;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = ST_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        // PC+4 and IR load only commit on the cycle the memory returns data.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded.
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = ST_MEM_ADDR;
          OP_RTYPE:          state_nxt = ST_EXECUTE;
          OP_BRANCH:         state_nxt = ST_BRANCH;
          default: begin
            // PC already advanced in FETCH, so the instruction is just dropped.
            illegal_instr = 1'b1;
            state_nxt     = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_nxt = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        state_nxt = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_nxt = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      end
      ST_EXECUTE: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = ALUOP_FUNCT;
        state_nxt = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = SRC_A_REG;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        state_nxt     = ST_FETCH;
      end
      // Unused encodings drive nothing and fall back to FETCH.
      default: state_nxt = ST_FETCH;
    endcase
  end

  // Funct bits only reach the ALU decoder for R-type execute.
  assign alu_control_input = {alu_op, (alu_op == ALUOP_FUNCT) ? {funct7_5, funct3} : 4'b0000};
  assign state_o           = state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: reset, lw, sw with stalls, R-type, beq, illegal.
// Checks 2 time units after each rising edge; inputs change at the same point.
// Expected control vectors are hand-written constants per state.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       funct7_5 = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write;
  logic       ir_write, reg_write, mem_to_reg, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b;
  logic [5:0] alu_control_input;
  logic [3:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  main_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control_input(alu_control_input),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Bit order: pcw pcwc pcs iord mr mw irw rw m2r | a[1:0] b[1:0] | aci[5:0] | ill
  function automatic logic [19:0] mk(input logic pcw, pcwc, pcs, io, mr, mw, irw, rw, m2r,
                                     input logic [1:0] a, b, input logic [5:0] aci,
                                     input logic ill);
    return {pcw, pcwc, pcs, io, mr, mw, irw, rw, m2r, a, b, aci, ill};
  endfunction

  function automatic logic [19:0] ctl();
    return {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
            reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_control_input, illegal_instr};
  endfunction

  // Hand-derived per-state control vectors.
  localparam logic [19:0] V_FETCH_RDY = {9'b100010100, 2'b00, 2'b01, 6'b000000, 1'b0};
  localparam logic [19:0] V_FETCH_WT  = {9'b000010000, 2'b00, 2'b01, 6'b000000, 1'b0};
  localparam logic [19:0] V_DECODE    = {9'b000000000, 2'b01, 2'b10, 6'b000000, 1'b0};
  localparam logic [19:0] V_DEC_ILL   = {9'b000000000, 2'b01, 2'b10, 6'b000000, 1'b1};
  localparam logic [19:0] V_MEM_ADDR  = {9'b000000000, 2'b10, 2'b10, 6'b000000, 1'b0};
  localparam logic [19:0] V_MEM_READ  = {9'b000110000, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [19:0] V_MEM_WB    = {9'b000000011, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [19:0] V_MEM_WRITE = {9'b000101000, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [19:0] V_ALU_WB    = {9'b000000010, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [19:0] V_BRANCH    = {9'b011000000, 2'b10, 2'b00, 6'b010000, 1'b0};

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [19:0] v;
    rst_n = 1'b0; mem_ready = 1'b0;
    #3;
    n_cmp++;
    if (state_o !== 4'd0) begin
      n_bad++; $display("FAIL reset_state: got %0d want 0", state_o);
    end
    n_cmp++;
    v = ctl();
    if (v !== V_FETCH_WT) begin
      n_bad++; $display("FAIL reset_outputs: got %05h want %05h", v, V_FETCH_WT);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    v = ctl();
    if (state_o !== 4'd0 || v !== V_FETCH_WT) begin
      n_bad++; $display("FAIL reset_release_hold: got st=%0d ctl=%05h want st=0 ctl=%05h",
                        state_o, v, V_FETCH_WT);
    end
  endtask

  task automatic test_lw();
    logic [3:0]  st[6];
    logic [19:0] vx[6];
    logic [19:0] v;
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    vx = '{V_FETCH_RDY, V_DECODE, V_MEM_ADDR, V_MEM_READ, V_MEM_WB, V_FETCH_RDY};
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      v = ctl();
      n_cmp++;
      if (state_o !== st[i] || v !== vx[i]) begin
        n_bad++; $display("FAIL lw_cycle%0d: got st=%0d ctl=%05h want st=%0d ctl=%05h",
                          i + 1, state_o, v, st[i], vx[i]);
      end
      if (i < 5) cyc();
    end
  endtask

  task automatic test_sw_stall();
    logic [3:0]  st[8];
    logic [19:0] vx[8];
    logic        mr[8];
    logic [19:0] v;
    st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    vx = '{V_FETCH_RDY, V_DECODE, V_MEM_ADDR, V_MEM_WRITE, V_MEM_WRITE, V_MEM_WRITE,
           V_MEM_WRITE, V_FETCH_RDY};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      v = ctl();
      n_cmp++;
      if (state_o !== st[i] || v !== vx[i]) begin
        n_bad++; $display("FAIL sw_cycle%0d: got st=%0d ctl=%05h want st=%0d ctl=%05h",
                          i + 1, state_o, v, st[i], vx[i]);
      end
      if (i < 7) cyc();
    end
  endtask

  // R-type with mem_ready low outside FETCH to show it is ignored there.
  task automatic test_rtype(input logic f7, input logic [2:0] f3, input logic [5:0] aci);
    logic [3:0]  st[5];
    logic [19:0] vx[5];
    logic        mr[5];
    logic [19:0] v;
    st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    vx = '{V_FETCH_RDY, V_DECODE, {9'b0, 2'b10, 2'b00, aci, 1'b0}, V_ALU_WB, V_FETCH_RDY};
    mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode = 7'b0110011; funct7_5 = f7; funct3 = f3;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i];
      #1;
      v = ctl();
      n_cmp++;
      if (state_o !== st[i] || v !== vx[i]) begin
        n_bad++; $display("FAIL rtype_%06b_cycle%0d: got st=%0d ctl=%05h want st=%0d ctl=%05h",
                          aci, i + 1, state_o, v, st[i], vx[i]);
      end
      if (i < 4) cyc();
    end
  endtask

  task automatic test_beq();
    logic [3:0]  st[4];
    logic [19:0] vx[4];
    logic [19:0] v;
    st = '{4'd0, 4'd1, 4'd8, 4'd0};
    vx = '{V_FETCH_RDY, V_DECODE, V_BRANCH, V_FETCH_RDY};
    opcode = 7'b1100011; funct7_5 = 1'b1; funct3 = 3'b111; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      v = ctl();
      n_cmp++;
      if (state_o !== st[i] || v !== vx[i]) begin
        n_bad++; $display("FAIL beq_cycle%0d: got st=%0d ctl=%05h want st=%0d ctl=%05h",
                          i + 1, state_o, v, st[i], vx[i]);
      end
      if (i < 3) cyc();
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  st[3];
    logic [19:0] vx[3];
    logic [19:0] v;
    st = '{4'd0, 4'd1, 4'd0};
    vx = '{V_FETCH_RDY, V_DEC_ILL, V_FETCH_RDY};
    opcode = 7'b0010011; funct7_5 = 1'b0; funct3 = 3'b000; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      v = ctl();
      n_cmp++;
      if (state_o !== st[i] || v !== vx[i]) begin
        n_bad++; $display("FAIL illegal_cycle%0d: got st=%0d ctl=%05h want st=%0d ctl=%05h",
                          i + 1, state_o, v, st[i], vx[i]);
      end
      if (i < 2) cyc();
    end
  endtask

  task automatic test_reset_mid_read();
    logic [19:0] v;
    opcode = 7'b0000011; mem_ready = 1'b1;
    cyc(); cyc();
    mem_ready = 1'b0;
    cyc();
    n_cmp++;
    if (state_o !== 4'd3) begin
      n_bad++; $display("FAIL midread_setup: got st=%0d want 3", state_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'd0) begin
      n_bad++; $display("FAIL midread_async_reset: got st=%0d want 0", state_o);
    end
    #1;
    rst_n = 1'b1;
    #1;
    v = ctl();
    n_cmp++;
    if (mem_read !== 1'b1 || ir_write !== 1'b0 || reg_write !== 1'b0 || v !== V_FETCH_WT) begin
      n_bad++; $display("FAIL midread_after_release: got ctl=%05h want %05h", v, V_FETCH_WT);
    end
    cyc();
    v = ctl();
    n_cmp++;
    if (state_o !== 4'd0 || v !== V_FETCH_WT) begin
      n_bad++; $display("FAIL midread_fetch_stall: got st=%0d ctl=%05h want st=0 ctl=%05h",
                        state_o, v, V_FETCH_WT);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype(1'b1, 3'b000, 6'b101000);
    test_rtype(1'b0, 3'b111, 6'b100111);
    test_beq();
    test_illegal();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
